exec_sequencer: RTL and testbench

//  Parametrised multi-cycle sequencer for long-latency execution units (FPU, UART, divider, ...).

---
 rtl/seq_pkg.sv | 19 +
 rtl/exec_sequencer_if.sv | 33 +++
 rtl/seq_watchdog.sv | 35 +++
 rtl/exec_sequencer.sv | 114 +++++++++++
 tb/tb_exec_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding, default sizes and unit indices for exec_sequencer
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB
    } seq_state_t;

    localparam int NUNITS_DEF = 4;
    localparam int CNT_W_DEF  = 8;

    localparam int U_FPU  = 0;
    localparam int U_UART = 1;
    localparam int U_DIV  = 2;
    localparam int U_AUX  = 3;

endpackage

// File: rtl/exec_sequencer_if.sv
// rtl/exec_sequencer_if.sv - decoder/unit handshake bundle for exec_sequencer
interface exec_sequencer_if
    import seq_pkg::*;
#(
    parameter int NUNITS = NUNITS_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    localparam int SEL_W = $clog2(NUNITS);

    logic              start;
    logic [SEL_W-1:0]  unit_sel;
    logic              flush;
    logic [NUNITS-1:0] unit_valid;
    logic              err_clr;
    logic [NUNITS-1:0] unit_go;
    logic              wb_en;
    logic              done;
    logic              busy;
    logic [SEL_W-1:0]  wb_sel;
    logic [CNT_W-1:0]  last_lat;
    logic              timeout_err;

    modport master (
        output start, unit_sel, flush, unit_valid, err_clr,
        input  unit_go, wb_en, done, busy, wb_sel, last_lat, timeout_err
    );

    modport slave (
        input  start, unit_sel, flush, unit_valid, err_clr,
        output unit_go, wb_en, done, busy, wb_sel, last_lat, timeout_err
    );

endinterface

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - saturating wait counter, limit compare and sticky timeout flag
module seq_watchdog #(
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    input  logic set,
    input  logic err_clr,
    output logic at_limit,
    output logic timeout_err
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (clear)
                cnt <= '0;
            else if (inc && !at_limit)
                cnt <= cnt + 1'b1;
            // a new timeout outranks a simultaneous clear request
            if (set)
                timeout_err <= 1'b1;
            else if (err_clr)
                timeout_err <= 1'b0;
        end
    end

    assign at_limit = (cnt == {CNT_W{1'b1}});

endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - go/valid/done sequencer for NUNITS long-latency units; watchdog under SEQ_WATCHDOG_EN
module exec_sequencer
    import seq_pkg::*;
#(
    parameter int                NUNITS    = NUNITS_DEF,
    parameter logic [NUNITS-1:0] HOLD_MASK = 4'b0010,
    parameter int                CNT_W     = CNT_W_DEF
) (
    input logic              clk,
    input logic              rst,
    exec_sequencer_if.slave  bus
);
    localparam int               SEL_W   = $clog2(NUNITS);
    localparam logic [SEL_W:0]   N_LIM   = (SEL_W + 1)'(NUNITS);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [NUNITS-1:0] ONE    = {{(NUNITS - 1){1'b0}}, 1'b1};

    seq_state_t       state;
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] cnt;
    logic             sel_ok;
    logic             valid_sel;
    logic             wd_expire;

    assign sel_ok    = ({1'b0, bus.unit_sel} < N_LIM);
    assign valid_sel = bus.unit_valid[sel];

`ifdef SEQ_WATCHDOG_EN
    logic wd_limit;

    seq_watchdog #(.CNT_W(CNT_W)) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .clear       (state == S_IDLE),
        .inc         ((state == S_ISSUE) || (state == S_WAIT)),
        .set         (wd_expire),
        .err_clr     (bus.err_clr),
        .at_limit    (wd_limit),
        .timeout_err (bus.timeout_err)
    );

    // flush and a same-cycle valid both pre-empt the timeout
    assign wd_expire = (state == S_WAIT) && wd_limit && !valid_sel && !bus.flush;
`else
    assign wd_expire       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            sel          <= '0;
            cnt          <= '0;
            bus.unit_go  <= '0;
            bus.wb_en    <= 1'b0;
            bus.done     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.wb_sel   <= '0;
            bus.last_lat <= '0;
        end else begin
            bus.unit_go <= '0;
            bus.wb_en   <= 1'b0;
            bus.done    <= 1'b0;
            if (bus.flush) begin
                state    <= S_IDLE;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start && sel_ok) begin
                            state       <= S_ISSUE;
                            sel         <= bus.unit_sel;
                            bus.wb_sel  <= bus.unit_sel;
                            cnt         <= '0;
                            bus.unit_go <= ONE << bus.unit_sel;
                            bus.busy    <= 1'b1;
                        end
                    end
                    S_ISSUE: begin
                        state <= S_WAIT;
                        cnt   <= cnt + 1'b1;
                        if (HOLD_MASK[sel])
                            bus.unit_go <= ONE << sel;
                    end
                    S_WAIT: begin
                        if (valid_sel) begin
                            state        <= S_WB;
                            bus.wb_en    <= 1'b1;
                            bus.done     <= 1'b1;
                            bus.last_lat <= cnt;
                        end else if (wd_expire) begin
                            state    <= S_IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            if (cnt != CNT_MAX)
                                cnt <= cnt + 1'b1;
                            if (HOLD_MASK[sel])
                                bus.unit_go <= ONE << sel;
                        end
                    end
                    S_WB: begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end
                    default: begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed scoreboard bench for exec_sequencer (watchdog steps under SEQ_WATCHDOG_EN)
module tb_exec_sequencer;
`ifdef SEQ_WATCHDOG_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 8;
`endif

    typedef struct {
        int sel;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    exec_sequencer_if #(.NUNITS(4), .CNT_W(CNT_W)) bus ();

    exec_sequencer #(.NUNITS(4), .HOLD_MASK(4'b0010), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] s);
        bus.start    = 1'b1;
        bus.unit_sel = s;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic push(input int s, input int l);
        exp_t e;
        e.sel = s;
        e.lat = l;
        sb.push_back(e);
    endtask

    // every done pulse must match the oldest expected completion
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.done === 1'b1) begin
                chk("done_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("wb_sel", 32'(bus.wb_sel), 32'(e.sel));
                    chk("last_lat", 32'(bus.last_lat), 32'(e.lat));
                    chk("wb_en_with_done", 32'(bus.wb_en), 32'd1);
                end
            end
        end
    end

    initial begin
        bus.start      = 1'b0;
        bus.unit_sel   = '0;
        bus.flush      = 1'b0;
        bus.unit_valid = '0;
        bus.err_clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        repeat (20) tick();
        chk("idle_go", 32'(bus.unit_go), 32'd0);
        chk("idle_wb_en", 32'(bus.wb_en), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_wb_sel", 32'(bus.wb_sel), 32'd0);
        chk("idle_last_lat", 32'(bus.last_lat), 32'd0);
        chk("idle_timeout", 32'(bus.timeout_err), 32'd0);

        // pulse unit 0, valid 3 cycles after go
        issue(2'd0);
        chk("u0_go_issue", 32'(bus.unit_go), 32'b0001);
        chk("u0_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("u0_go_pulse_drop", 32'(bus.unit_go), 32'd0);
        tick();
        tick();
        bus.unit_valid = 4'b0001;
        push(0, 3);
        tick();
        bus.unit_valid = '0;
        chk("u0_done", 32'(bus.done), 32'd1);
        chk("u0_go_wb", 32'(bus.unit_go), 32'd0);
        tick();
        chk("u0_done_one_cycle", 32'(bus.done), 32'd0);
        chk("u0_idle", 32'(bus.busy), 32'd0);

        // hold unit 1, valid 5 cycles after go: go high 6 cycles
        issue(2'd1);
        chk("u1_go_issue", 32'(bus.unit_go), 32'b0010);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("u1_go_held", 32'(bus.unit_go), 32'b0010);
        end
        bus.unit_valid = 4'b0010;
        push(1, 5);
        tick();
        bus.unit_valid = '0;
        chk("u1_go_drop_wb", 32'(bus.unit_go), 32'd0);
        chk("u1_done", 32'(bus.done), 32'd1);
        tick();

        // unit 2 busy: foreign valid and repeated start are ignored
        issue(2'd2);
        chk("u2_go_issue", 32'(bus.unit_go), 32'b0100);
        tick();
        bus.unit_valid = 4'b1000;
        bus.start      = 1'b1;
        bus.unit_sel   = 2'd1;
        tick();
        bus.unit_valid = '0;
        chk("u2_ignore_busy", 32'(bus.busy), 32'd1);
        chk("u2_ignore_done", 32'(bus.done), 32'd0);
        tick();
        bus.start      = 1'b0;
        bus.unit_valid = 4'b0100;
        push(2, 3);
        tick();
        bus.unit_valid = '0;
        chk("u2_done", 32'(bus.done), 32'd1);
        tick();
        chk("u2_idle", 32'(bus.busy), 32'd0);

        // flush beats a same-cycle valid
        issue(2'd0);
        tick();
        tick();
        bus.unit_valid = 4'b0001;
        bus.flush      = 1'b1;
        tick();
        bus.unit_valid = '0;
        bus.flush      = 1'b0;
        chk("fl_busy", 32'(bus.busy), 32'd0);
        chk("fl_done", 32'(bus.done), 32'd0);
        chk("fl_wb_en", 32'(bus.wb_en), 32'd0);
        chk("fl_last_lat", 32'(bus.last_lat), 32'd3);
        tick();
        chk("fl_still_idle", 32'(bus.busy), 32'd0);

        // flush during issue
        issue(2'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fl_issue_busy", 32'(bus.busy), 32'd0);
        chk("fl_issue_go", 32'(bus.unit_go), 32'd0);

`ifdef SEQ_WATCHDOG_EN
        issue(2'd1);
        repeat (15) tick();
        chk("wd_still_wait", 32'(bus.busy), 32'd1);
        chk("wd_go_held", 32'(bus.unit_go), 32'b0010);
        tick();
        chk("wd_idle", 32'(bus.busy), 32'd0);
        chk("wd_flag", 32'(bus.timeout_err), 32'd1);
        chk("wd_go_off", 32'(bus.unit_go), 32'd0);
        bus.unit_valid = 4'b0010;
        tick();
        bus.unit_valid = '0;
        chk("wd_late_valid", 32'(bus.busy), 32'd0);
        chk("wd_sticky", 32'(bus.timeout_err), 32'd1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("wd_clear", 32'(bus.timeout_err), 32'd0);
`else
        // latency counter saturates at 2^CNT_W-1
        issue(2'd3);
        repeat (300) tick();
        chk("sat_busy", 32'(bus.busy), 32'd1);
        bus.unit_valid = 4'b1000;
        push(3, 255);
        tick();
        bus.unit_valid = '0;
        chk("sat_done", 32'(bus.done), 32'd1);
        chk("sat_no_timeout", 32'(bus.timeout_err), 32'd0);
        tick();
`endif

        // asynchronous reset mid-operation
        issue(2'd1);
        tick();
        chk("ar_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_go", 32'(bus.unit_go), 32'd0);
        chk("ar_last_lat", 32'(bus.last_lat), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("ar_idle_after", 32'(bus.busy), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
